// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      DATA,
      DONE
   } state_e;

   localparam int          BYTES_PER_WORD = 4;
   localparam logic [31:0] NOP_WORD       = 32'h0800_0000;

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word packer; word_valid_o fires on the byte that completes a word.
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        shift_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_valid_o
);

   localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] buf_q, buf_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         buf_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         buf_q <= buf_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      buf_d = buf_q;
      if (clr_i) begin
         cnt_d = '0;
         buf_d = '0;
      end else if (shift_i) begin
         cnt_d = cnt_q + 2'd1;
         buf_d = {buf_q[15:0], byte_i};
      end
   end

   // The completing byte is merged combinationally so the word is usable this cycle.
   assign word_o       = {buf_q, byte_i};
   assign word_valid_o = shift_i && !clr_i && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed program image from the UART into instruction memory,
// holding the CPU until the image is complete.
module program_loader
   import loader_pkg::*;
#(
   parameter int INST_MEM_WIDTH = 2
) (
   input  logic                      CLK,
   input  logic                      reset,
   input  logic                      load_start,
   input  logic [7:0]                rx_data,
   input  logic                      rx_valid,
   output logic                      mem_we,
   output logic [INST_MEM_WIDTH-1:0] mem_addr,
   output logic [31:0]               mem_wdata,
   output logic                      loading,
   output logic                      cpu_start,
   output logic                      overflow
);

   localparam logic [31:0] DEPTH = 32'(1) << INST_MEM_WIDTH;

   state_e                    state_q, state_d;
   logic [31:0]               n_q, n_d;
   logic [31:0]               wcnt_q, wcnt_d;
   logic                      we_q, we_d;
   logic [INST_MEM_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]               wdata_q, wdata_d;
   logic                      ovf_q, ovf_d;

   logic        in_load;
   logic        shift;
   logic [31:0] word;
   logic        word_valid;

   assign in_load = (state_q == COUNT) || (state_q == DATA);
   assign shift   = rx_valid && !load_start && in_load;

   word_assembler u_asm (
      .clk_i        (CLK),
      .rst_i        (reset),
      .clr_i        (load_start),
      .shift_i      (shift),
      .byte_i       (rx_data),
      .word_o       (word),
      .word_valid_o (word_valid)
   );

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         n_q     <= '0;
         wcnt_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         wcnt_q  <= wcnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      wcnt_d  = wcnt_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ovf_d   = ovf_q;
      if (load_start) begin
         state_d = COUNT;
         n_d     = '0;
         wcnt_d  = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: ;
            DONE: ;
            COUNT: begin
               if (word_valid) begin
                  n_d     = word;
                  state_d = (word == 32'd0) ? DONE : DATA;
               end
            end
            DATA: begin
               if (word_valid) begin
                  wcnt_d = wcnt_q + 32'd1;
                  // Words beyond the memory are drained so the stream stays aligned.
                  if (wcnt_q < DEPTH) begin
                     we_d    = 1'b1;
                     addr_d  = wcnt_q[INST_MEM_WIDTH-1:0];
                     wdata_d = word;
                  end else begin
                     ovf_d = 1'b1;
                  end
                  if (wcnt_q + 32'd1 == n_q) begin
                     state_d = DONE;
                  end
               end
            end
         endcase
      end
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign loading   = in_load;
   assign cpu_start = (state_q == DONE);
   assign overflow  = ovf_q;

endmodule
